// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the instruction port, the data port and the RAM port of the
//   memory arbiter.
//   modport slave  : the arbiter. It takes the cache requests and RAM
//                    responses, and drives the hits, the loads and the RAM
//                    request.
//   modport master : the surroundings (caches and RAM). This is the mirror
//                    image of slave.
//   Signals:
//     iREN/iaddr -> ihit/iload                 instruction read
//     dREN/dWEN/daddr/dstore -> dhit/dload     data read/write
//     ramREN/ramWEN/ramaddr/ramstore           arbiter -> RAM
//     ramstate/ramload                         RAM -> arbiter
//       ramstate: FREE=0, BUSY=1, ACCESS=2, ERROR=3
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [1:0]  ramstate;
  logic [31:0] ramload;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates one RAM port between an instruction requester and a data
//   requester. Data requests have priority. An instruction request that is
//   kept waiting is served after DSTREAK_MAX data grants in a row.
//   The granted request is latched when the grant is entered. The RAM
//   outputs are driven only from those latches, so they hold steady until
//   the RAM answers with ACCESS.
//
//   Ports:
//     CLK      in   system clock, rising edge
//     RST      in   asynchronous, active-high reset
//     bus      if   mem_arbiter_if.slave (cache ports and RAM port)
//     arb_err  out  one-cycle pulse when a transaction is aborted on timeout
//
//   Parameters:
//     DSTREAK_MAX     data grants allowed in a row while iREN waits (<= 7)
//     TIMEOUT_CYCLES  RAM wait limit in cycles (used only with the timer)
//
//   Build option:
//     ARB_TIMEOUT_EN  when defined, adds an 8-bit wait counter that aborts a
//                     grant that gets no ACCESS within TIMEOUT_CYCLES cycles.
//                     When undefined, a grant waits forever and arb_err is 0.
//
//   state  | meaning
//   IDLE   | no transaction; pick the next requester
//   IGRANT | instruction read presented to RAM, waiting for ACCESS
//   DGRANT | data read/write presented to RAM, waiting for ACCESS
//   IRESP  | ihit pulse with iload valid (unless the request was dropped)
//   DRESP  | dhit pulse with dload valid (unless the request was dropped)
module mem_arbiter #(
  parameter int DSTREAK_MAX    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus,
  output logic         arb_err
);

  typedef enum logic [2:0] {IDLE, IGRANT, DGRANT, IRESP, DRESP} state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_e      state_q, state_d;
  logic [2:0]  dstreak_q, dstreak_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic        drop_q, drop_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]  wcnt_q, wcnt_d;
  logic        err_q, err_d;
`endif

  logic data_req;
  logic req_held;
  logic in_grant;

  assign data_req = bus.dREN | bus.dWEN;
  assign in_grant = (state_q == IGRANT) || (state_q == DGRANT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      addr_q    <= '0;
      store_q   <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      drop_q    <= 1'b0;
      iload_q   <= '0;
      dload_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      wcnt_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      drop_q    <= drop_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
`ifdef ARB_TIMEOUT_EN
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    addr_d    = addr_q;
    store_d   = store_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    drop_d    = drop_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    req_held  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    err_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (!bus.iREN) dstreak_d = '0;
        // Data wins unless the instruction side has already watched
        // DSTREAK_MAX data grants go by.
        if (data_req && !(bus.iREN && (dstreak_q == 3'(DSTREAK_MAX)))) begin
          state_d = DGRANT;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          // A write takes precedence when dREN and dWEN are both high.
          wen_d   = bus.dWEN;
          ren_d   = ~bus.dWEN;
          drop_d  = 1'b0;
          if (bus.iREN && (dstreak_q != 3'd7)) dstreak_d = dstreak_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end else if (bus.iREN) begin
          state_d   = IGRANT;
          addr_d    = bus.iaddr;
          store_d   = '0;
          ren_d     = 1'b1;
          wen_d     = 1'b0;
          drop_d    = 1'b0;
          dstreak_d = '0;
`ifdef ARB_TIMEOUT_EN
          wcnt_d    = '0;
`endif
        end
      end

      IGRANT, DGRANT: begin
        req_held = (state_q == IGRANT) ? bus.iREN : data_req;
        // A dropped request still runs on the RAM, so that a write is
        // committed; it only loses its hit.
        if (!req_held) drop_d = 1'b1;
        // FREE, BUSY and ERROR all keep the latched request on the bus.
        // For ERROR this presents the same request again on the next cycle.
        if (bus.ramstate == RAM_ACCESS) begin
          if (state_q == IGRANT) begin
            iload_d = bus.ramload;
            state_d = IRESP;
          end else begin
            dload_d = bus.ramload;
            state_d = DRESP;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // wcnt_q counts grant cycles already spent. The abort happens on the
        // edge that would bring it to TIMEOUT_CYCLES.
        else if (wcnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
`endif
      end

      IRESP, DRESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign bus.ramREN   = in_grant & ren_q;
  assign bus.ramWEN   = in_grant & wen_q;
  assign bus.ramaddr  = in_grant ? addr_q  : '0;
  assign bus.ramstore = in_grant ? store_q : '0;

  assign bus.ihit  = (state_q == IRESP) & ~drop_q;
  assign bus.dhit  = (state_q == DRESP) & ~drop_q;
  assign bus.iload = iload_q;
  assign bus.dload = dload_q;

`ifdef ARB_TIMEOUT_EN
  assign arb_err = err_q;
`else
  // The timer is not built. This expression is constant 0 for any legal
  // (non-negative) TIMEOUT_CYCLES.
  assign arb_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule
